// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the block_fetch instruction
// fetch unit.
//   fetch_state_e : fetch FSM states (S_TRAP exists only when
//                   BLOCK_FETCH_MISALIGN_TRAP_EN is defined)
//   fetch_entry_t : one instruction buffer entry {instr, pc}
//   RESET_PC_DEFAULT, FETCH_BUF_DEPTH, instruction field bit positions
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FETCH_BUF_DEPTH  = 2;

  localparam int OP_LSB     = 0;
  localparam int OP_MSB     = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_BIT = 30;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
    ,
    S_TRAP  = 2'd3
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- 2-entry in-order instruction buffer holding {instr, pc}.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_entry  : enqueue an entry
//   pop               : dequeue the head (ignored when empty)
//   flush             : drop all entries (wins over push/pop)
//   head_valid, head  : current head entry
//   count             : occupancy 0..2
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         head_valid,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [FETCH_BUF_DEPTH];
  // Single-bit pointers: toggling wraps exactly at two entries.
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop     = pop && (count != 2'd0);
  assign do_push    = push && ((count != 2'(FETCH_BUF_DEPTH)) || do_pop);
  assign head_valid = (count != 2'd0);
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/block_fetch.sv
// block_fetch -- instruction fetch unit: issues sequential fetch requests,
// buffers in-order responses with their PC, and handles redirects by
// flushing the buffer and discarding responses still in flight.
// Optional feature macro: BLOCK_FETCH_MISALIGN_TRAP_EN (misaligned redirect
// target traps until reset and exposes o_misaligned).
// Ports:
//   i_clk, i_rst                        : clock, synchronous active-high reset
//   o_imem_req_valid/i_imem_req_ready   : request handshake, o_imem_addr = PC
//   i_imem_rsp_valid/i_imem_rsp_data    : in-order memory responses
//   i_pc_src/i_pc_target                : redirect strobe and target
//   o_instr_valid/i_instr_ready         : buffer head handshake to decode
//   o_instr/o_instr_pc                  : head instruction and its PC
//   o_op/o_funct3/o_funct7              : head instruction fields
//   o_misaligned                        : sticky trap flag (macro only)
//
// state   | meaning
// S_BOOT  | one idle cycle after reset, no requests
// S_RUN   | normal fetch, request while in-flight + buffered < 2
// S_FLUSH | after redirect, discarding stale responses
// S_TRAP  | misaligned redirect seen, halted until reset (macro only)
module block_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_pc_src,
  input  logic [31:0] i_pc_target,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
  output logic        o_misaligned,
`endif
  output logic [6:0]  o_op,
  output logic [2:0]  o_funct3,
  output logic        o_funct7
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [1:0]   outst, outst_n;
  logic [1:0]   drop, drop_n;
  logic [1:0]   outst_after;
  logic [1:0]   occ;
  logic [2:0]   in_flight;
  logic         accept;
  logic         rsp_take;
  logic         push;
  logic         flush;
  logic         pop;
  logic         redirect;
  logic [31:0]  target;
  logic         head_valid;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign target           = i_pc_target & ~32'h3;
  assign in_flight        = {1'b0, outst} + {1'b0, occ};
  assign o_imem_req_valid = (state == S_RUN) && (in_flight < 3'(BUF_DEPTH));
  assign accept           = o_imem_req_valid && i_imem_req_ready;
  assign o_imem_addr      = pc;
  assign rsp_take         = i_imem_rsp_valid &&
                            (((state == S_RUN) && (outst != 2'd0)) ||
                             ((state == S_FLUSH) && (drop != 2'd0)));
  assign outst_after      = outst + {1'b0, accept} - {1'b0, rsp_take};
  assign pop              = head_valid && i_instr_ready;

  // Requests are issued back-to-back from pc, so the oldest outstanding
  // request (the one this response answers) sits outst words behind pc.
  assign push_entry.instr = i_imem_rsp_data;
  assign push_entry.pc    = pc - {28'd0, outst, 2'b00};

`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
  logic misaligned, misaligned_n;
  assign o_misaligned = misaligned;
  assign redirect     = i_pc_src && (state != S_TRAP);
`else
  assign redirect     = i_pc_src;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    outst_n = outst;
    drop_n  = drop;
    push    = 1'b0;
    flush   = 1'b0;
`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
    misaligned_n = misaligned;
`endif
    case (state)
      S_BOOT: state_n = S_RUN;
      S_RUN: begin
        if (accept) pc_n = pc + 32'd4;
        outst_n = outst_after;
        push    = rsp_take;
      end
      S_FLUSH: begin
        drop_n = drop - {1'b0, rsp_take};
        if (rsp_take && (drop == 2'd1)) state_n = S_RUN;
      end
`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
      S_TRAP: state_n = S_TRAP;
`endif
      default: state_n = S_BOOT;
    endcase

    // Redirect overrides this cycle's accept and response: the accepted
    // old-PC request joins the drop count, the response is discarded.
    if (redirect) begin
      flush = 1'b1;
      push  = 1'b0;
      pc_n  = target;
      if (state == S_RUN) begin
        drop_n  = outst_after;
        outst_n = 2'd0;
        state_n = (outst_after != 2'd0) ? S_FLUSH : S_RUN;
      end
`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
      if (i_pc_target[1:0] != 2'b00) begin
        state_n      = S_TRAP;
        misaligned_n = 1'b1;
        pc_n         = pc;
        outst_n      = 2'd0;
        drop_n       = 2'd0;
      end
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_BOOT;
      pc    <= RESET_PC;
      outst <= 2'd0;
      drop  <= 2'd0;
`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      state <= state_n;
      pc    <= pc_n;
      outst <= outst_n;
      drop  <= drop_n;
`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
      misaligned <= misaligned_n;
`endif
    end
  end

  fetch_fifo u_fifo (
    .clk        (i_clk),
    .rst        (i_rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head_valid (head_valid),
    .head       (head),
    .count      (occ)
  );

  assign o_instr_valid = head_valid;
  assign o_instr       = head.instr;
  assign o_instr_pc    = head.pc;
  assign o_op          = head.instr[OP_MSB:OP_LSB];
  assign o_funct3      = head.instr[FUNCT3_MSB:FUNCT3_LSB];
  assign o_funct7      = head.instr[FUNCT7_BIT];

endmodule

// File: tb/tb_block_fetch.sv
module tb_block_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] imem_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  block_fetch dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_addr      (imem_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_pc_src         (pc_src),
    .i_pc_target      (pc_target),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
    .o_misaligned     (misaligned),
`endif
    .o_op             (op),
    .o_funct3         (funct3),
    .o_funct7         (funct7)
  );

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_head(input string name, input logic [31:0] exp_pc);
    logic [31:0] w;
    w = memfn(exp_pc);
    chk({name, "_pc"}, instr_pc, exp_pc);
    chk({name, "_instr"}, instr, w);
    chk({name, "_op"}, {25'd0, op}, {25'd0, w[6:0]});
    chk({name, "_f3"}, {29'd0, funct3}, {29'd0, w[14:12]});
    chk({name, "_f7"}, {31'd0, funct7}, {31'd0, w[30]});
  endtask

  // Drive inputs at the negedge, take one rising edge, return at the negedge.
  task automatic drive(input logic rdy, input logic rv, input logic [31:0] raddr,
                       input logic ps, input logic [31:0] tgt, input logic ir);
    req_ready   = rdy;
    rsp_valid   = rv;
    rsp_data    = memfn(raddr);
    pc_src      = ps;
    pc_target   = tgt;
    instr_ready = ir;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] raddr;
    logic        ir;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    bit          live;
  } mq_t;

  vec_t        vecs[11];
  mq_t         memq[$];
  logic [31:0] bufq[$];
  logic [31:0] nxt;
  bit          boot;

  initial begin
    rst = 1'b1; req_ready = 0; rsp_valid = 0; rsp_data = 0;
    pc_src = 0; pc_target = 0; instr_ready = 0;

    // rdy rv raddr ir | req addr iv pc
    vecs[0]  = '{1, 0, 32'h0, 0,  0, 32'h0, 0, 32'h0};
    vecs[1]  = '{1, 0, 32'h0, 0,  1, 32'h0, 0, 32'h0};
    vecs[2]  = '{1, 1, 32'h0, 0,  1, 32'h4, 0, 32'h0};
    vecs[3]  = '{1, 1, 32'h4, 0,  0, 32'h8, 1, 32'h0};
    vecs[4]  = '{1, 0, 32'h0, 0,  0, 32'h8, 1, 32'h0};
    vecs[5]  = '{1, 0, 32'h0, 1,  0, 32'h8, 1, 32'h0};
    vecs[6]  = '{0, 0, 32'h0, 0,  1, 32'h8, 1, 32'h4};
    vecs[7]  = '{1, 0, 32'h0, 1,  1, 32'h8, 1, 32'h4};
    vecs[8]  = '{0, 1, 32'h8, 1,  1, 32'hC, 0, 32'h0};
    vecs[9]  = '{0, 0, 32'h0, 1,  1, 32'hC, 1, 32'h8};
    vecs[10] = '{0, 0, 32'h0, 0,  1, 32'hC, 0, 32'h0};

    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_fields", {20'd0, op, funct3, funct7, 1'b0}, 32'd0);
`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
`endif
    rst = 1'b0;

    // Startup, full buffer back-pressure, address hold while not ready.
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("vec%0d_req", i), {31'd0, req_valid}, {31'd0, vecs[i].exp_req});
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_iv", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_iv});
      if (vecs[i].exp_iv) chk_head($sformatf("vec%0d", i), vecs[i].exp_pc);
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].raddr, 1'b0, 32'd0, vecs[i].ir);
    end

    // Redirect in the same cycle as an accept, with two requests in flight.
    drive(1, 0, 0, 0, 0, 1);
    chk("redir_pre_addr", imem_addr, 32'h10);
    drive(1, 0, 0, 1, 32'h100, 1);
    chk("flush_no_req", {31'd0, req_valid}, 32'd0);
    chk("flush_addr", imem_addr, 32'h100);
    drive(1, 1, 32'hC, 0, 0, 1);
    chk("flush_drop1_req", {31'd0, req_valid}, 32'd0);
    chk("flush_drop1_iv", {31'd0, instr_valid}, 32'd0);
    drive(1, 1, 32'h10, 0, 0, 1);
    chk("flush_drop2_iv", {31'd0, instr_valid}, 32'd0);
    chk("flush_done_req", {31'd0, req_valid}, 32'd1);
    chk("flush_done_addr", imem_addr, 32'h100);
    drive(1, 0, 0, 0, 0, 0);
    chk("redir_next_addr", imem_addr, 32'h104);
    drive(0, 1, 32'h100, 0, 0, 0);
    chk("redir_head_iv", {31'd0, instr_valid}, 32'd1);
    chk_head("redir_head", 32'h100);
    drive(0, 0, 0, 0, 0, 1);

    // PC wrap at the top of the address space.
    drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_req", {31'd0, req_valid}, 32'd1);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0, 0, 0);
    chk("wrap_addr_zero", imem_addr, 32'h0);
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    chk_head("wrap_head", 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 1);

    // Reset with a request in flight: the late response must be ignored.
    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    do_reset();
    drive(0, 1, 32'h0, 0, 0, 0);
    drive(0, 1, 32'h0, 0, 0, 0);
    chk("rst_mid_iv", {31'd0, instr_valid}, 32'd0);
    chk("rst_mid_req", {31'd0, req_valid}, 32'd1);
    chk("rst_mid_addr", imem_addr, 32'h0);

`ifdef BLOCK_FETCH_MISALIGN_TRAP_EN
    drive(0, 0, 0, 1, 32'h102, 0);
    chk("trap_flag", {31'd0, misaligned}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("trap_no_req", {31'd0, req_valid}, 32'd0);
      drive(1, 0, 0, 1, 32'h200, 1);
    end
    chk("trap_sticky", {31'd0, misaligned}, 32'd1);
    do_reset();
    chk("trap_cleared", {31'd0, misaligned}, 32'd0);
`else
    drive(0, 0, 0, 1, 32'h102, 0);
    chk("target_masked", imem_addr, 32'h100);
`endif

    // Randomised traffic against a stream-level reference model.
    do_reset();
    memq.delete();
    bufq.delete();
    nxt  = 32'h0;
    boot = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        exp_req, acc, rdy, rv, ps, ir;
      logic [31:0] tgt, raddr;
      int          dead;
      dead = 0;
      foreach (memq[k]) if (!memq[k].live) dead++;
      exp_req = !boot && (dead == 0) && ((memq.size() + bufq.size()) < 2);
      chk("rnd_req", {31'd0, req_valid}, {31'd0, exp_req});
      if (exp_req) chk("rnd_addr", imem_addr, nxt);
      chk("rnd_iv", {31'd0, instr_valid}, {31'd0, bufq.size() > 0});
      if (bufq.size() > 0) begin
        chk("rnd_pc", instr_pc, bufq[0]);
        chk("rnd_instr", instr, memfn(bufq[0]));
      end

      rdy   = ($urandom % 4) != 0;
      ir    = ($urandom % 3) != 0;
      ps    = ($urandom % 16) == 0;
      tgt   = (($urandom % 4) == 0) ? (32'hFFFF_FFF8 | (32'($urandom % 2) << 2))
                                    : ($urandom & ~32'h3);
      if (memq.size() > 0) begin
        rv    = ($urandom % 3) != 0;
        raddr = memq[0].addr;
      end else begin
        rv    = ($urandom % 16) == 0;
        raddr = $urandom;
      end

      acc = exp_req && rdy;
      if (bufq.size() > 0 && ir && !ps) void'(bufq.pop_front());
      if (rv && memq.size() > 0) begin
        mq_t e;
        e = memq.pop_front();
        if (e.live && !ps) bufq.push_back(e.addr);
      end
      if (acc) begin
        memq.push_back('{nxt, !ps});
        nxt = nxt + 32'd4;
      end
      if (ps) begin
        bufq.delete();
        foreach (memq[k]) memq[k].live = 1'b0;
        nxt = tgt & ~32'h3;
      end
      boot = 1'b0;

      drive(rdy, rv, raddr, ps, tgt, ir);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
